// File: rtl/cdc_src_arb_clear_ctrl.sv
// Source-domain controller for a clearable 2-phase CDC channel: round-robin
// arbitration of NUM_REQ requesters plus sequencing of software, watchdog and remote clears.
module cdc_src_arb_clear_ctrl #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 41,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          clear_req_i,
  output logic [DATA_WIDTH-1:0]         cdc_data_o,
  output logic                          cdc_valid_o,
  input  logic                          cdc_ready_i,
  output logic                          cdc_clear_o,
  input  logic                          cdc_clear_pending_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          timeout_o,
  output logic                          drop_o,
  output logic [7:0]                    clear_count_o
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, GRANT, CLEAR_ISSUE, CLEAR_WAIT_RISE, CLEAR_WAIT_FALL
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d, gidx_q, gidx_d, pick, ptr_inc;
  logic [TW-1:0]   wdog_q, wdog_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            drop_pend_q, drop_pend_d;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    g_onehot;
  logic in_grant, g_valid, ext, stall, hs, wd_fire;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign in_grant = (state_q == GRANT);
  assign g_valid  = req_valid_i[gidx_q];
  assign g_onehot = NUM_REQ'(1) << gidx_q;
  assign ext      = cdc_clear_pending_i;
  assign stall    = in_grant & g_valid & ~cdc_ready_i;
  // A beat offered while the remote side is clearing is never acknowledged.
  assign hs       = in_grant & g_valid & cdc_ready_i & ~ext;
  assign wd_fire  = stall & ~ext & (wdog_q == TW'(TIMEOUT_CYCLES - 1));
  assign ptr_inc  = (int'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + 1'b1;

  assign cdc_valid_o   = in_grant & g_valid;
  assign cdc_data_o    = in_grant ? data_arr[gidx_q] : '0;
  assign req_ready_o   = (in_grant & cdc_ready_i & ~ext) ? g_onehot : '0;
  assign grant_o       = in_grant ? g_onehot : '0;
  assign busy_o        = (state_q == CLEAR_ISSUE) || (state_q == CLEAR_WAIT_RISE) ||
                         (state_q == CLEAR_WAIT_FALL);
  assign cdc_clear_o   = (state_q == CLEAR_ISSUE) & ~rst_i;
  assign timeout_o     = wd_fire;
  assign drop_o        = (in_grant & g_valid & ext) | wd_fire |
                         ((state_q == CLEAR_ISSUE) & drop_pend_q);
  assign clear_count_o = cnt_q;

  // Iterate downward so the lowest offset from the pointer wins.
  always_comb begin
    pick = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[(int'(ptr_q) + i) % NUM_REQ]) pick = GW'((int'(ptr_q) + i) % NUM_REQ);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    wdog_d      = '0;
    cnt_d       = cnt_q;
    drop_pend_d = drop_pend_q;
    case (state_q)
      IDLE: begin
        if (ext) state_d = CLEAR_WAIT_FALL;
        else if (clear_req_i) begin
          state_d     = CLEAR_ISSUE;
          cnt_d       = cnt_q + 8'd1;
          drop_pend_d = 1'b0;
        end else if (|req_valid_i) begin
          state_d = GRANT;
          gidx_d  = pick;
        end
      end
      GRANT: begin
        if (ext) state_d = CLEAR_WAIT_FALL;
        else begin
          if (hs) ptr_d = ptr_inc;
          if (clear_req_i || wd_fire) begin
            state_d     = CLEAR_ISSUE;
            cnt_d       = cnt_q + 8'd1;
            drop_pend_d = g_valid & ~hs & ~wd_fire;
          end else if (hs) state_d = IDLE;
          else if (stall) wdog_d = wdog_q + 1'b1;
        end
      end
      CLEAR_ISSUE: begin
        state_d     = CLEAR_WAIT_RISE;
        drop_pend_d = 1'b0;
      end
      CLEAR_WAIT_RISE: if (ext) state_d = CLEAR_WAIT_FALL;
      CLEAR_WAIT_FALL: if (!ext) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      wdog_q      <= '0;
      cnt_q       <= '0;
      drop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      wdog_q      <= wdog_d;
      cnt_q       <= cnt_d;
      drop_pend_q <= drop_pend_d;
    end
  end

endmodule

// File: tb/tb_cdc_src_arb_clear_ctrl.sv
// Directed bench for cdc_src_arb_clear_ctrl: arbitration order, wrap, watchdog,
// clear sequencing, remote clears, reset mid-clear and clear counter wrap.
module tb_cdc_src_arb_clear_ctrl;

  localparam int NR = 4;
  localparam int DW = 41;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [NR-1:0]   req_valid_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]   req_ready_o;
  logic            clear_req_i;
  logic [DW-1:0]   cdc_data_o;
  logic            cdc_valid_o;
  logic            cdc_ready_i;
  logic            cdc_clear_o;
  logic            cdc_clear_pending_i;
  logic [NR-1:0]   grant_o;
  logic            busy_o, timeout_o, drop_o;
  logic [7:0]      clear_count_o;

  int tests_run = 0;
  int tests_failed = 0;

  cdc_src_arb_clear_ctrl #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .clear_req_i(clear_req_i), .cdc_data_o(cdc_data_o),
    .cdc_valid_o(cdc_valid_o), .cdc_ready_i(cdc_ready_i), .cdc_clear_o(cdc_clear_o),
    .cdc_clear_pending_i(cdc_clear_pending_i), .grant_o(grant_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .drop_o(drop_o), .clear_count_o(clear_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation still running, required to finish");
    $fatal(1);
  end

  // Advance one clock; inputs are driven and outputs sampled 2-3 time units after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_valid_i = '0; clear_req_i = 1'b0; cdc_ready_i = 1'b0;
    cdc_clear_pending_i = 1'b0;
    for (int k = 0; k < NR; k++) req_data_i[k*DW +: DW] = 41'h1_0000_0000 + 41'(k);
    cyc(); cyc();
    rst_i = 1'b0; #1;
    tests_run++;
    if ({grant_o, req_ready_o, cdc_valid_o, cdc_clear_o, busy_o, timeout_o, drop_o} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl_outputs: got %b required 0", {grant_o, req_ready_o, cdc_valid_o, cdc_clear_o, busy_o, timeout_o, drop_o});
    end
    tests_run++;
    if (clear_count_o !== 8'd0 || cdc_data_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_count_data: got count %0d data %h required 0/0", clear_count_o, cdc_data_o);
    end
  endtask

  task automatic test_round_robin();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    logic [NR-1:0] e;
    req_valid_i = 4'hF; cdc_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      e = 4'b0001 << exp_g[i];
      tests_run++;
      if (grant_o !== e || req_ready_o !== e || cdc_valid_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_grant_%0d: got grant %b ready %b valid %b required %b/%b/1", i, grant_o, req_ready_o, cdc_valid_o, e, e);
      end
      tests_run++;
      if (cdc_data_o !== 41'h1_0000_0000 + 41'(exp_g[i])) begin
        tests_failed++;
        $display("FAIL rr_data_%0d: got %h required %h", i, cdc_data_o, 41'h1_0000_0000 + 41'(exp_g[i]));
      end
      cyc(); #1;
      tests_run++;
      if (grant_o !== 4'b0000) begin
        tests_failed++;
        $display("FAIL rr_gap_%0d: got grant %b required 0000", i, grant_o);
      end
      if (i == 4) req_valid_i = '0;
    end
  endtask

  // Pointer is 1 on entry; a transfer on requester 2 moves it to 3.
  task automatic test_wrap();
    req_valid_i = 4'b0100; cdc_ready_i = 1'b1;
    cyc(); #1;
    tests_run++;
    if (grant_o !== 4'b0100) begin
      tests_failed++;
      $display("FAIL wrap_pre_grant: got %b required 0100", grant_o);
    end
    cyc(); cyc(); #1;
    tests_run++;
    if (grant_o !== 4'b0100) begin
      tests_failed++;
      $display("FAIL wrap_grant_ptr3: got %b required 0100", grant_o);
    end
    cyc();
    req_valid_i = 4'hF;
    cyc(); #1;
    tests_run++;
    if (grant_o !== 4'b1000) begin
      tests_failed++;
      $display("FAIL wrap_ptr_kept_3: got %b required 1000", grant_o);
    end
    cyc();
    req_valid_i = '0;
  endtask

  // Pointer is 0 on entry; ends at 2.
  task automatic test_timeout();
    req_valid_i = 4'b0010; cdc_ready_i = 1'b0;
    cyc();
    for (int k = 1; k <= 7; k++) begin
      #1;
      tests_run++;
      if (timeout_o !== 1'b0 || drop_o !== 1'b0 || cdc_valid_o !== 1'b1 || grant_o !== 4'b0010) begin
        tests_failed++;
        $display("FAIL to_stall_%0d: got to %b drop %b valid %b grant %b required 0/0/1/0010", k, timeout_o, drop_o, cdc_valid_o, grant_o);
      end
      cyc();
    end
    #1;
    tests_run++;
    if (timeout_o !== 1'b1 || drop_o !== 1'b1 || cdc_clear_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_fire: got to %b drop %b clr %b required 1/1/0", timeout_o, drop_o, cdc_clear_o);
    end
    cyc(); #1;
    tests_run++;
    if (cdc_clear_o !== 1'b1 || drop_o !== 1'b0 || timeout_o !== 1'b0 || busy_o !== 1'b1 ||
        grant_o !== 4'b0 || cdc_valid_o !== 1'b0 || req_ready_o !== 4'b0 || clear_count_o !== 8'd1) begin
      tests_failed++;
      $display("FAIL to_issue: got clr %b drop %b to %b busy %b grant %b valid %b rdy %b cnt %0d required 1/0/0/1/0000/0/0000/1",
               cdc_clear_o, drop_o, timeout_o, busy_o, grant_o, cdc_valid_o, req_ready_o, clear_count_o);
    end
    cyc(); #1;
    tests_run++;
    if (cdc_clear_o !== 1'b0 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_wait_rise: got clr %b busy %b required 0/1", cdc_clear_o, busy_o);
    end
    cdc_clear_pending_i = 1'b1;
    cyc(); cyc();
    cdc_clear_pending_i = 1'b0; #1;
    tests_run++;
    if (busy_o !== 1'b1 || grant_o !== 4'b0) begin
      tests_failed++;
      $display("FAIL to_wait_fall: got busy %b grant %b required 1/0000", busy_o, grant_o);
    end
    cyc(); #1;
    tests_run++;
    if (busy_o !== 1'b0 || grant_o !== 4'b0) begin
      tests_failed++;
      $display("FAIL to_idle: got busy %b grant %b required 0/0000", busy_o, grant_o);
    end
    cyc(); #1;
    tests_run++;
    if (grant_o !== 4'b0010 || cdc_data_o !== 41'h1_0000_0001) begin
      tests_failed++;
      $display("FAIL to_regrant: got grant %b data %h required 0010/100000001", grant_o, cdc_data_o);
    end
    cdc_ready_i = 1'b1;
    cyc();
    req_valid_i = '0;
  endtask

  // Pointer is 2 on entry; requester 0 is reached by wrapping, ends at 1.
  task automatic test_clear_handshake();
    req_valid_i = 4'b0001; cdc_ready_i = 1'b1;
    cyc();
    clear_req_i = 1'b1; #1;
    tests_run++;
    if (grant_o !== 4'b0001 || req_ready_o !== 4'b0001 || drop_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ch_handshake: got grant %b rdy %b drop %b required 0001/0001/0", grant_o, req_ready_o, drop_o);
    end
    cyc();
    clear_req_i = 1'b0; req_valid_i = '0; #1;
    tests_run++;
    if (cdc_clear_o !== 1'b1 || drop_o !== 1'b0 || busy_o !== 1'b1 || clear_count_o !== 8'd2) begin
      tests_failed++;
      $display("FAIL ch_issue: got clr %b drop %b busy %b cnt %0d required 1/0/1/2", cdc_clear_o, drop_o, busy_o, clear_count_o);
    end
    cyc();
    cdc_clear_pending_i = 1'b1;
    cyc();
    cdc_clear_pending_i = 1'b0; #1;
    tests_run++;
    if (busy_o !== 1'b1 || cdc_clear_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ch_busy_hold: got busy %b clr %b required 1/0", busy_o, cdc_clear_o);
    end
    cyc(); #1;
    tests_run++;
    if (busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ch_busy_release: got %b required 0", busy_o);
    end
  endtask

  // Pointer is 1 on entry.
  task automatic test_ext_clear();
    req_valid_i = 4'b0010; cdc_ready_i = 1'b0;
    cyc();
    cdc_clear_pending_i = 1'b1; #1;
    tests_run++;
    if (drop_o !== 1'b1 || cdc_clear_o !== 1'b0 || req_ready_o !== 4'b0) begin
      tests_failed++;
      $display("FAIL ext_drop: got drop %b clr %b rdy %b required 1/0/0000", drop_o, cdc_clear_o, req_ready_o);
    end
    cyc(); #1;
    tests_run++;
    if (busy_o !== 1'b1 || drop_o !== 1'b0 || cdc_clear_o !== 1'b0 || clear_count_o !== 8'd2) begin
      tests_failed++;
      $display("FAIL ext_wait_fall: got busy %b drop %b clr %b cnt %0d required 1/0/0/2", busy_o, drop_o, cdc_clear_o, clear_count_o);
    end
    cdc_clear_pending_i = 1'b0; req_valid_i = '0;
    cyc(); #1;
    tests_run++;
    if (busy_o !== 1'b0 || grant_o !== 4'b0) begin
      tests_failed++;
      $display("FAIL ext_idle: got busy %b grant %b required 0/0000", busy_o, grant_o);
    end
  endtask

  task automatic test_reset_mid_clear();
    clear_req_i = 1'b1;
    cyc();
    clear_req_i = 1'b0; #1;
    tests_run++;
    if (cdc_clear_o !== 1'b1 || clear_count_o !== 8'd3) begin
      tests_failed++;
      $display("FAIL rmc_issue: got clr %b cnt %0d required 1/3", cdc_clear_o, clear_count_o);
    end
    cyc();
    cdc_clear_pending_i = 1'b1;
    cyc();
    rst_i = 1'b1; cdc_clear_pending_i = 1'b0;
    cyc();
    rst_i = 1'b0; #1;
    tests_run++;
    if (busy_o !== 1'b0 || clear_count_o !== 8'd0 || grant_o !== 4'b0 || drop_o !== 1'b0 ||
        timeout_o !== 1'b0 || cdc_clear_o !== 1'b0 || cdc_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmc_after_reset: got busy %b cnt %0d grant %b drop %b to %b clr %b valid %b required all 0",
               busy_o, clear_count_o, grant_o, drop_o, timeout_o, cdc_clear_o, cdc_valid_o);
    end
    req_valid_i = 4'hF; cdc_ready_i = 1'b1;
    cyc(); #1;
    tests_run++;
    if (grant_o !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rmc_ptr_reset: got %b required 0001", grant_o);
    end
    cyc();
    req_valid_i = '0;
    clear_req_i = 1'b1;
    cyc();
    clear_req_i = 1'b0;
    rst_i = 1'b1; #1;
    tests_run++;
    if (cdc_clear_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmc_clear_immediate: got %b required 0", cdc_clear_o);
    end
    cyc();
    rst_i = 1'b0; #1;
    tests_run++;
    if (busy_o !== 1'b0 || clear_count_o !== 8'd0) begin
      tests_failed++;
      $display("FAIL rmc_issue_reset: got busy %b cnt %0d required 0/0", busy_o, clear_count_o);
    end
  endtask

  task automatic test_count_wrap();
    for (int n = 1; n <= 256; n++) begin
      clear_req_i = 1'b1;
      cyc();
      clear_req_i = 1'b0;
      cyc();
      cdc_clear_pending_i = 1'b1;
      cyc();
      cdc_clear_pending_i = 1'b0;
      cyc(); #1;
      if (n == 255) begin
        tests_run++;
        if (clear_count_o !== 8'd255) begin
          tests_failed++;
          $display("FAIL wrap_count_255: got %0d required 255", clear_count_o);
        end
      end
    end
    tests_run++;
    if (clear_count_o !== 8'd0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_count_0: got cnt %0d busy %b required 0/0", clear_count_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_clear_handshake();
    test_ext_clear();
    test_reset_mid_clear();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
